// File: rtl/countdown_timer_4bit_pkg.sv
// Shared definitions for the 4-bit countdown timer: count width, count type and FSM states.
package countdown_timer_4bit_pkg;

    localparam int unsigned CD_W = 4;

    typedef logic [CD_W-1:0] cd_count_t;

    typedef enum logic [1:0] {
        CD_IDLE = 2'd0,
        CD_RUN  = 2'd1,
        CD_DONE = 2'd2
    } cd_state_t;

endpackage

// File: rtl/countdown_timer_4bit_dec.sv
// decrement_by_1: combinational x-1 stage (adds all-ones), with unsigned carry and signed overflow.
module decrement_by_1
    import countdown_timer_4bit_pkg::*;
(
    input  logic [CD_W-1:0] x,
    output logic [CD_W-1:0] s,
    output logic            carry,
    output logic            overflow
);

    logic [CD_W:0] sum;

    assign sum      = {1'b0, x} + {1'b0, {CD_W{1'b1}}};
    assign s        = sum[CD_W-1:0];
    assign carry    = sum[CD_W];
    // Adding -1 overflows only when a negative x wraps to a positive result.
    assign overflow = x[CD_W-1] & ~s[CD_W-1];

endmodule

// File: rtl/countdown_timer_4bit.sv
// Loadable 4-bit countdown timer with one-cycle done pulse.
// Optional `COUNTDOWN_AUTO_RELOAD_EN: DONE reloads the captured start value and keeps running.
module countdown_timer_4bit
    import countdown_timer_4bit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CD_W-1:0] load_val,
    input  logic            tick,
    input  logic            abort,
    output logic            ready,
    output logic            busy,
    output logic [CD_W-1:0] count,
    output logic            done
);

    cd_state_t state_q, state_d;
    cd_count_t count_q, count_d;
    cd_count_t dec_s;
    logic      dec_carry_unused;
    logic      dec_overflow_unused;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    cd_count_t reload_q, reload_d;
`endif

    decrement_by_1 u_dec (
        .x        (count_q),
        .s        (dec_s),
        .carry    (dec_carry_unused),
        .overflow (dec_overflow_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CD_IDLE;
            count_q  <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        unique case (state_q)
            CD_IDLE: begin
                if (start) begin
                    count_d  = load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_d = load_val;
`endif
                    state_d  = (load_val == '0) ? CD_DONE : CD_RUN;
                end
            end
            CD_RUN: begin
                if (abort) begin
                    state_d = CD_IDLE;
                    count_d = '0;
                end else if (count_q == '0) begin
                    // Only reachable after a zero reload; expire without touching the decrementer.
                    state_d = CD_DONE;
                end else if (tick) begin
                    count_d = dec_s;
                    if (count_q == cd_count_t'(1)) begin
                        state_d = CD_DONE;
                    end
                end
            end
            CD_DONE: begin
                if (abort) begin
                    state_d = CD_IDLE;
                    count_d = '0;
                end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    state_d = CD_RUN;
                    count_d = reload_q;
`else
                    state_d = CD_IDLE;
`endif
                end
            end
            default: begin
                state_d = CD_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign ready = (state_q == CD_IDLE);
    assign busy  = (state_q == CD_RUN);
    assign done  = (state_q == CD_DONE);
    assign count = count_q;

endmodule

// File: tb/tb_countdown_timer_4bit.sv
// Directed bench for countdown_timer_4bit: interval model checked every cycle plus literal spot checks.
module tb_countdown_timer_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] load_val;
    logic       tick;
    logic       abort;
    logic       ready;
    logic       busy;
    logic [3:0] count;
    logic       done;

    int errors = 0;
    int checks = 0;

    countdown_timer_4bit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .tick     (tick),
        .abort    (abort),
        .ready    (ready),
        .busy     (busy),
        .count    (count),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Model: remaining ticks, whether an interval is running, whether it just expired.
    int m_left    = 0;
    int m_reload  = 0;
    bit m_running = 0;
    bit m_expired = 0;
    bit m_valid   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_reload = 0; m_running = 0; m_expired = 0; m_valid = 1;
        end else if (m_expired) begin
            m_expired = 0;
            if (abort) begin
                m_left = 0;
            end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                m_running = 1;
                m_left    = m_reload;
`endif
            end
        end else if (m_running) begin
            if (abort) begin
                m_running = 0; m_left = 0;
            end else if (m_left == 0) begin
                m_running = 0; m_expired = 1;
            end else if (tick) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_running = 0; m_expired = 1;
                end
            end
        end else if (start) begin
            m_left   = int'(load_val);
            m_reload = int'(load_val);
            if (m_left == 0) m_expired = 1;
            else m_running = 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count", int'(count), m_left);
            check("model_busy",  int'(busy),  int'(m_running));
            check("model_done",  int'(done),  int'(m_expired));
            check("model_ready", int'(ready), int'(!m_running && !m_expired));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; load_val = '0; tick = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", int'(ready), 1);
        check("reset_busy",  int'(busy),  0);
        check("reset_count", int'(count), 0);
        check("reset_done",  int'(done),  0);

        // Basic countdown from 5 with continuous tick
        start = 1'b1; load_val = 4'd5; tick = 1'b1;
        cyc();
        start = 1'b0;
        check("load5_count", int'(count), 5);
        check("load5_busy",  int'(busy),  1);
        for (int v = 4; v >= 1; v--) begin
            cyc();
            check("down_count", int'(count), v);
        end
        cyc();
        check("exp5_count", int'(count), 0);
        check("exp5_done",  int'(done),  1);
        check("exp5_ready", int'(ready), 0);
        cyc();
        check("after5_ready", int'(ready), 1);
        check("after5_done",  int'(done),  0);

        // Zero load expires immediately
        start = 1'b1; load_val = 4'd0;
        cyc();
        start = 1'b0;
        check("zero_done",  int'(done),  1);
        check("zero_count", int'(count), 0);
        check("zero_ready", int'(ready), 0);
        cyc();
        check("zero_ready_back", int'(ready), 1);

        // Tick gaps with a dropped mid-run start
        start = 1'b1; load_val = 4'd3; tick = 1'b0;
        cyc();
        start = 1'b0;
        check("gap_load", int'(count), 3);
        tick = 1'b1; cyc();
        check("gap_t1", int'(count), 2);
        tick = 1'b0; start = 1'b1; load_val = 4'd9; cyc();
        start = 1'b0;
        check("gap_hold_drop", int'(count), 2);
        tick = 1'b1; cyc();
        check("gap_t2", int'(count), 1);
        tick = 1'b0; cyc();
        check("gap_hold2", int'(count), 1);
        tick = 1'b1; cyc();
        check("gap_t3",   int'(count), 0);
        check("gap_done", int'(done),  1);
        tick = 1'b0; cyc();
        check("gap_ready", int'(ready), 1);

        // Abort beats tick at count 4
        start = 1'b1; load_val = 4'd9; tick = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        check("abort_pre", int'(count), 4);
        abort = 1'b1; cyc();
        abort = 1'b0;
        check("abort_count", int'(count), 0);
        check("abort_ready", int'(ready), 1);
        check("abort_done",  int'(done),  0);
        cyc();
        check("abort_nodone", int'(done), 0);

        // Abort in idle does not block an accepted start
        start = 1'b1; load_val = 4'd2; abort = 1'b1; tick = 1'b0;
        cyc();
        start = 1'b0;
        check("idle_abort_load", int'(count), 2);
        check("idle_abort_busy", int'(busy),  1);
        cyc();
        abort = 1'b0;
        check("run_abort_ready", int'(ready), 1);

        // Reset mid-run at count 6
        start = 1'b1; load_val = 4'd9; tick = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        check("rst_pre", int'(count), 6);
        rst = 1'b1; cyc();
        rst = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_busy",  int'(busy),  0);
        check("rst_done",  int'(done),  0);

        // Full-scale load: 15 ticks from start edge to expiry
        start = 1'b1; load_val = 4'd15; tick = 1'b1;
        cyc();
        start = 1'b0;
        check("full_load", int'(count), 15);
        n = 0;
        while (!done && n < 40) begin
            cyc();
            n++;
        end
        check("full_ticks", n, 15);
        cyc();
        check("full_ready", int'(ready), 1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Auto reload from 2: expiry every 3 cycles, ready held low
        start = 1'b1; load_val = 4'd2; tick = 1'b1;
        cyc();
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            cyc(); cyc();
            check("ar_done",  int'(done),  1);
            check("ar_ready", int'(ready), 0);
            cyc();
            check("ar_reload", int'(count), 2);
        end
        abort = 1'b1; cyc();
        abort = 1'b0;
        check("ar_abort_ready", int'(ready), 1);
`endif

        tick = 1'b0;
        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
